// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - command/response bus bundle shared by both masters and the slave port
//
// Purpose: one bus segment (read/write command plus response) between a bus
// master and a bus slave.
// Signals:
//   read, write   command strobes, held by the master until completion
//   dataena       byte enables (DW/8)
//   burstcount    beats in the burst, 0 means a single beat
//   addr, wdata   command address and write data
//   valid, rdata  read response beat
//   waitrequest   slave stall for the current command
// Modports:
//   master  - the side that issues commands
//   slave   - the side that accepts commands and returns responses
interface bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            read;
  logic            write;
  logic [DW/8-1:0] dataena;
  logic [3:0]      burstcount;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic            valid;
  logic [DW-1:0]   rdata;
  logic            waitrequest;

  modport master (
    output read, write, dataena, burstcount, addr, wdata,
    input  valid, rdata, waitrequest
  );

  modport slave (
    input  read, write, dataena, burstcount, addr, wdata,
    output valid, rdata, waitrequest
  );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin arbiter onto a single slave port
//
// Purpose: shares one slave port between m0 (instruction fetch) and m1 (data).
// A grant is taken in IDLE, held for the whole burst and released after the
// last beat or when the granted master withdraws its request.
// Ports:
//   clk     rising-edge clock for all state
//   rst     asynchronous active-high reset
//   m0_if   master 0 segment (arbiter is the slave side)
//   m1_if   master 1 segment (arbiter is the slave side)
//   s_if    slave port segment (arbiter is the master side)
module bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.slave  m0_if,
  bus_arbiter_if.slave  m1_if,
  bus_arbiter_if.master s_if
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t     state_q;
  logic       last_grant_q;   // index of the master that held the bus last
  logic [3:0] beats_q;        // beats expected in the current burst
  logic [3:0] cnt_q;          // beats completed so far

  logic            req0;
  logic            req1;
  logic            pick0;
  logic [3:0]      bc_sel;
  logic [3:0]      beats_d;
  logic [3:0]      cnt_d;

  logic            g_read;
  logic            g_write;
  logic [DW/8-1:0] g_dataena;
  logic [3:0]      g_burstcount;
  logic [AW-1:0]   g_addr;
  logic [DW-1:0]   g_wdata;
  logic            g_req;
  logic            beat;
  logic            last_beat;

  assign req0 = m0_if.read | m0_if.write;
  assign req1 = m1_if.read | m1_if.write;

  // m0 wins when it is alone or when m1 was served last.
  assign pick0   = req0 & (~req1 | last_grant_q);
  assign bc_sel  = pick0 ? m0_if.burstcount : m1_if.burstcount;
  assign beats_d = (bc_sel == 4'd0) ? 4'd1 : bc_sel;
  assign cnt_d   = cnt_q + 4'd1;

  // Command mux: the granted master's fields, all-zero while IDLE.
  always_comb begin
    g_read       = 1'b0;
    g_write      = 1'b0;
    g_dataena    = '0;
    g_burstcount = '0;
    g_addr       = '0;
    g_wdata      = '0;
    case (state_q)
      GRANT0: begin
        g_read       = m0_if.read;
        g_write      = m0_if.write;
        g_dataena    = m0_if.dataena;
        g_burstcount = m0_if.burstcount;
        g_addr       = m0_if.addr;
        g_wdata      = m0_if.wdata;
      end
      GRANT1: begin
        g_read       = m1_if.read;
        g_write      = m1_if.write;
        g_dataena    = m1_if.dataena;
        g_burstcount = m1_if.burstcount;
        g_addr       = m1_if.addr;
        g_wdata      = m1_if.wdata;
      end
      default: ;
    endcase
  end

  assign s_if.read       = g_read;
  assign s_if.write      = g_write;
  assign s_if.dataena    = g_dataena;
  assign s_if.burstcount = g_burstcount;
  assign s_if.addr       = g_addr;
  assign s_if.wdata      = g_wdata;

  assign m0_if.waitrequest = (state_q == GRANT0) ? s_if.waitrequest : 1'b1;
  assign m1_if.waitrequest = (state_q == GRANT1) ? s_if.waitrequest : 1'b1;
  assign m0_if.valid       = (state_q == GRANT0) & s_if.valid;
  assign m1_if.valid       = (state_q == GRANT1) & s_if.valid;
  assign m0_if.rdata       = s_if.rdata;
  assign m1_if.rdata       = s_if.rdata;

  // A read beat is a returned s_valid; a write beat is an accepted s_write.
  // With both strobes up the read side decides what counts as a beat.
  assign g_req     = g_read | g_write;
  assign beat      = g_read ? s_if.valid : (g_write & ~s_if.waitrequest);
  assign last_beat = beat & (cnt_d == beats_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      beats_q      <= 4'd1;
      cnt_q        <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= 4'd0;
          if (req0 | req1) begin
            state_q <= pick0 ? GRANT0 : GRANT1;
            beats_q <= beats_d;
          end
        end
        GRANT0, GRANT1: begin
          // Withdrawal and final beat both close the grant and rotate priority.
          if (!g_req || last_beat) begin
            state_q      <= IDLE;
            last_grant_q <= (state_q == GRANT1);
          end else if (beat) begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter with a transaction-level owner model
module tb_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
  bus_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();
  bus_arbiter_if #(.AW(AW), .DW(DW)) s_if ();

  logic            rd    [2];
  logic            wr    [2];
  logic [3:0]      bc    [2];
  logic [AW-1:0]   addr  [2];
  logic [DW-1:0]   wdata [2];
  logic [DW/8-1:0] be    [2];
  logic            sval;
  logic            swait;
  logic [DW-1:0]   srdata;

  assign m0_if.read       = rd[0];
  assign m0_if.write      = wr[0];
  assign m0_if.burstcount = bc[0];
  assign m0_if.addr       = addr[0];
  assign m0_if.wdata      = wdata[0];
  assign m0_if.dataena    = be[0];
  assign m1_if.read       = rd[1];
  assign m1_if.write      = wr[1];
  assign m1_if.burstcount = bc[1];
  assign m1_if.addr       = addr[1];
  assign m1_if.wdata      = wdata[1];
  assign m1_if.dataena    = be[1];
  assign s_if.valid       = sval;
  assign s_if.rdata       = srdata;
  assign s_if.waitrequest = swait;

  bus_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .m0_if (m0_if),
    .m1_if (m1_if),
    .s_if  (s_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the bus, who owned it last, burst progress.
  int owner  = -1;
  int last_g = 1;
  int beats  = 1;
  int cnt    = 0;
  int done_n = -1;
  int dut_gl[$];   // master seen on the slave port at each grant
  int pat[7] = '{0, 1, 1, 1, 0, 0, 0};

  task automatic ck(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic req(input int n);
    return rd[n] | wr[n];
  endfunction

  function automatic logic mwait(input int n);
    return (n == 1) ? m1_if.waitrequest : m0_if.waitrequest;
  endfunction

  function automatic logic mvalid(input int n);
    return (n == 1) ? m1_if.valid : m0_if.valid;
  endfunction

  task automatic new_req(input int n, input logic r, input logic w, input logic [3:0] b);
    rd[n]    = r;
    wr[n]    = w;
    bc[n]    = b;
    addr[n]  = $urandom;
    wdata[n] = $urandom;
    be[n]    = 4'($urandom);
  endtask

  task automatic drop(input int n);
    rd[n]    = 1'b0;
    wr[n]    = 1'b0;
    bc[n]    = 4'd0;
    addr[n]  = '0;
    wdata[n] = '0;
    be[n]    = '0;
  endtask

  // Advance one clock and apply the arbitration rules to what the masters
  // and slave presented during the cycle that just ended.
  task automatic adv();
    @(posedge clk);
    #1;
    done_n = -1;
    if (rst) begin
      owner  = -1;
      last_g = 1;
      cnt    = 0;
    end else if (owner < 0) begin
      if (req(0) && req(1)) owner = 1 - last_g;
      else if (req(0))      owner = 0;
      else if (req(1))      owner = 1;
      if (owner >= 0) begin
        beats = (bc[owner] == 4'd0) ? 1 : int'(bc[owner]);
        cnt   = 0;
        dut_gl.push_back((s_if.addr === addr[1] && s_if.addr !== addr[0]) ? 1 : 0);
      end
    end else begin
      if (!req(owner)) begin
        last_g = owner;
        done_n = owner;
        owner  = -1;
      end else begin
        if (rd[owner] ? sval : !swait) cnt++;
        if (cnt == beats) begin
          last_g = owner;
          done_n = owner;
          owner  = -1;
        end
      end
    end
  endtask

  task automatic chk_all();
    #1;
    if (owner < 0) begin
      ck("idle_s_read",  s_if.read, 1'b0);
      ck("idle_s_write", s_if.write, 1'b0);
      ck("idle_s_addr",  s_if.addr, '0);
      ck("idle_s_wdata", s_if.wdata, '0);
      ck("idle_s_be",    s_if.dataena, '0);
      ck("idle_s_bc",    s_if.burstcount, '0);
      ck("idle_m0_wait", m0_if.waitrequest, 1'b1);
      ck("idle_m1_wait", m1_if.waitrequest, 1'b1);
      ck("idle_m0_val",  m0_if.valid, 1'b0);
      ck("idle_m1_val",  m1_if.valid, 1'b0);
    end else begin
      ck("fwd_read",   s_if.read, rd[owner]);
      ck("fwd_write",  s_if.write, wr[owner]);
      ck("fwd_addr",   s_if.addr, addr[owner]);
      ck("fwd_wdata",  s_if.wdata, wdata[owner]);
      ck("fwd_be",     s_if.dataena, be[owner]);
      ck("fwd_bc",     s_if.burstcount, bc[owner]);
      ck("own_wait",   mwait(owner), swait);
      ck("own_valid",  mvalid(owner), sval);
      ck("oth_wait",   mwait(1 - owner), 1'b1);
      ck("oth_valid",  mvalid(1 - owner), 1'b0);
    end
    ck("m0_rdata", m0_if.rdata, srdata);
    ck("m1_rdata", m1_if.rdata, srdata);
  endtask

  // Run with a random slave until a grant closes; the finishing master drops.
  task automatic serve(input int max_cycles);
    logic got;
    got = 1'b0;
    for (int k = 0; k < max_cycles; k++) begin
      sval   = 1'($urandom_range(0, 1));
      swait  = 1'($urandom_range(0, 1));
      srdata = $urandom;
      chk_all();
      adv();
      if (done_n >= 0) begin
        drop(done_n);
        got = 1'b1;
        break;
      end
    end
    ck("serve_within_bound", got, 1'b1);
  endtask

  task automatic do_reset();
    drop(0);
    drop(1);
    sval  = 1'b0;
    swait = 1'b0;
    rst   = 1'b1;
    owner  = -1;
    last_g = 1;
    cnt    = 0;
    chk_all();
    adv();
    rst = 1'b0;
    chk_all();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rw;
    rst = 1'b1;
    drop(0);
    drop(1);
    sval   = 1'b0;
    swait  = 1'b0;
    srdata = '0;
    #3;
    chk_all();
    adv();
    rst = 1'b0;
    chk_all();

    // Single m0 read, one beat, response two cycles after the command.
    adv(); new_req(0, 1'b1, 1'b0, 4'd1); srdata = $urandom; chk_all();
    ck("029_pre_grant_wait", m0_if.waitrequest, 1'b1);
    adv(); chk_all(); ck("029_s_read_n1", s_if.read, 1'b1);
    adv(); chk_all();
    adv(); sval = 1'b1; srdata = $urandom; chk_all();
    ck("029_m0_valid", m0_if.valid, 1'b1);
    ck("029_rdata", m0_if.rdata, srdata);
    adv(); ck("029_idle_next", s_if.read, 1'b0);
    drop(0); sval = 1'b0; chk_all();

    // Simultaneous requests after reset: m0 first, m1 after one IDLE cycle.
    do_reset();
    adv(); new_req(0, 1'b1, 1'b0, 4'd1); new_req(1, 1'b1, 1'b0, 4'd1); chk_all();
    adv(); chk_all();
    ck("030_m0_first", s_if.addr, addr[0]);
    ck("030_m1_held", m1_if.waitrequest, 1'b1);
    serve(40);
    chk_all(); ck("030_gap_m1_wait", m1_if.waitrequest, 1'b1);
    adv(); chk_all(); ck("030_m1_second", s_if.addr, addr[1]);
    serve(40);
    chk_all();

    // m1 4-beat write, beat 2 stalled three cycles, m0 held off throughout.
    adv(); new_req(1, 1'b0, 1'b1, 4'd4); sval = 1'b0; swait = 1'b0; chk_all();
    adv(); new_req(0, 1'b1, 1'b0, 4'd1);
    for (int i = 0; i < 7; i++) begin
      swait = (pat[i] != 0);
      chk_all();
      ck("031_m0_held", m0_if.waitrequest, 1'b1);
      ck("031_granted", s_if.write, 1'b1);
      if (i < 6) adv();
    end
    adv(); ck("031_idle_after_4", s_if.write, 1'b0);
    drop(1); swait = 1'b0; chk_all();
    serve(40);
    chk_all();

    // Continuous requests from both masters: grants alternate.
    do_reset();
    dut_gl.delete();
    for (int n = 0; n < 2; n++) begin
      rw = 2'($urandom_range(1, 3));
      new_req(n, rw[0], rw[1], 4'($urandom_range(0, 4)));
    end
    chk_all();
    for (int t = 0; t < 6; t++) begin
      serve(80);
      if (done_n >= 0) begin
        rw = 2'($urandom_range(1, 3));
        new_req(done_n, rw[0], rw[1], 4'($urandom_range(0, 4)));
      end
      chk_all();
    end
    drop(0); drop(1); chk_all();
    ck("032_grant_count_ge6", dut_gl.size() >= 6, 1'b1);
    for (int t = 0; t < 6 && t < dut_gl.size(); t++)
      ck($sformatf("032_alt_%0d", t), dut_gl[t], t % 2);

    // Burstcount 0 is one beat; then an abort followed by a stray s_valid.
    adv(); new_req(0, 1'b1, 1'b0, 4'd0); sval = 1'b0; swait = 1'b0; chk_all();
    adv(); chk_all(); ck("033_bc0_forwarded", s_if.burstcount, 4'd0);
    sval = 1'b1; srdata = $urandom; chk_all();
    adv(); ck("033_one_beat_idle", s_if.read, 1'b0);
    drop(0); sval = 1'b0; chk_all();
    adv(); new_req(0, 1'b1, 1'b0, 4'd0); chk_all();
    adv(); chk_all(); ck("033_regrant", s_if.read, 1'b1);
    adv(); drop(0); chk_all();
    adv(); sval = 1'b1; srdata = $urandom; chk_all();
    ck("033_stray_m0", m0_if.valid, 1'b0);
    ck("033_stray_m1", m1_if.valid, 1'b0);
    adv(); chk_all();
    sval = 1'b0;

    // Reset during beat 2 of an m1 burst; m0 wins the first contention after.
    adv(); new_req(1, 1'b0, 1'b1, 4'd4); swait = 1'b0; chk_all();
    adv(); new_req(0, 1'b1, 1'b0, 4'd2); chk_all();
    adv(); chk_all(); ck("034_beat2_write", s_if.write, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    owner  = -1;
    last_g = 1;
    cnt    = 0;
    ck("034_s_write_rst", s_if.write, 1'b0);
    ck("034_m1_wait_rst", m1_if.waitrequest, 1'b1);
    chk_all();
    adv(); rst = 1'b0; chk_all();
    adv(); chk_all();
    ck("034_m0_first", s_if.addr, addr[0]);
    ck("034_m1_held", m1_if.waitrequest, 1'b1);
    serve(60);
    chk_all();
    serve(80);
    chk_all();

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      adv();
      if (done_n >= 0) drop(done_n);
      for (int n = 0; n < 2; n++) begin
        if (!req(n) && n != done_n && $urandom_range(0, 2) == 0) begin
          rw = 2'($urandom_range(1, 3));
          new_req(n, rw[0], rw[1], 4'($urandom_range(0, 15)));
        end else if (owner == n && $urandom_range(0, 40) == 0) begin
          drop(n);
        end
      end
      sval   = 1'($urandom_range(0, 1));
      swait  = 1'($urandom_range(0, 1));
      srdata = $urandom;
      chk_all();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
